// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment link receiver: default frame width,
// receiver FSM state encoding and the digit blank code used by the decoder.
package sseg_pkg;

  localparam int SSEG_FRAME_BITS = 64;

  localparam logic [3:0] SSEG_DIGIT_BLANK = 4'hf;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } sseg_state_e;

endpackage

// File: rtl/sseg_rx_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall strobes. The level output
// is the edge-detect register, so it lines up with the strobes cycle for cycle.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din_i};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl_o  = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sseg_rx.sv
// Seven-segment link receiver: rebuilds the serial frame and flags bad lengths.
// Define SSEG_RX_FRAME_CNT_EN to add the good/error frame counters.
module sseg_rx
  import sseg_pkg::*;
#(
  parameter int FRAME_BITS  = SSEG_FRAME_BITS,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_i,
  input  logic                  load_i,
  input  logic                  sdi,
  output logic [FRAME_BITS-1:0] seg_o,
  output logic                  frame_vld,
  output logic                  frame_err,
  output logic                  busy
`ifdef SSEG_RX_FRAME_CNT_EN
  ,
  output logic [15:0]           good_cnt,
  output logic [7:0]            err_cnt
`endif
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic sclk_lvl, sclk_re, sclk_fe;
  logic load_lvl, load_re, load_fe;
  logic sdi_s, sdi_re, sdi_fe;
  logic unused_sync;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din_i(sclk_i),
    .lvl_o(sclk_lvl), .rise_o(sclk_re), .fall_o(sclk_fe)
  );

  // Link idles high, so the load chain resets to 1 to avoid a false fall.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_load (
    .clk(clk), .rst(rst), .din_i(load_i),
    .lvl_o(load_lvl), .rise_o(load_re), .fall_o(load_fe)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .rst(rst), .din_i(sdi),
    .lvl_o(sdi_s), .rise_o(sdi_re), .fall_o(sdi_fe)
  );

  assign unused_sync = ^{sclk_lvl, sclk_fe, load_lvl, sdi_re, sdi_fe};

  sseg_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [FRAME_BITS-1:0]   seg_q, seg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    vld_q, vld_d;
  logic                    err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_fe) state_d = ST_SHIFT;
      ST_SHIFT: if (load_re) state_d = ST_CHECK;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A coincident sclk_re and load_re in SHIFT still shifts the final bit.
  always_comb begin
    shreg_d = shreg_q;
    seg_d   = seg_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_fe) cnt_d = '0;
      end
      ST_SHIFT: begin
        if (sclk_re) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], sdi_s};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        cnt_d = '0;
        if (cnt_q == FULL_CNT) begin
          seg_d = shreg_q;
          vld_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
      seg_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    busy      = (state_q == ST_SHIFT);
    seg_o     = seg_q;
    frame_vld = vld_q;
    frame_err = err_q;
  end

`ifdef SSEG_RX_FRAME_CNT_EN
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // Good count wraps; error count sticks at its maximum.
  always_comb begin
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (vld_d) good_cnt_d = good_cnt_q + 16'd1;
    if (err_d && (err_cnt_q != 8'hff)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign good_cnt = good_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_sseg_rx.sv
// Bench for sseg_rx: drives the three-wire link at clk/8 and compares each
// frame outcome against a length-based reference model.
module tb_sseg_rx;

  localparam int FB  = 64;
  localparam int SS  = 2;
  localparam int LAT = SS + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sclk_i = 1'b0;
  logic          load_i = 1'b1;
  logic          sdi = 1'b0;
  logic [FB-1:0] seg_o;
  logic          frame_vld;
  logic          frame_err;
  logic          busy;
`ifdef SSEG_RX_FRAME_CNT_EN
  logic [15:0]   good_cnt;
  logic [7:0]    err_cnt;
`endif

  int            errors = 0;
  int            checks = 0;
  logic [FB-1:0] seg_exp = '0;
  int            gcnt_exp = 0;
  int            ecnt_exp = 0;

  sseg_rx #(.FRAME_BITS(FB), .SYNC_STAGES(SS), .CNT_W(7)) dut (
    .clk(clk),
    .rst(rst),
    .sclk_i(sclk_i),
    .load_i(load_i),
    .sdi(sdi),
    .seg_o(seg_o),
    .frame_vld(frame_vld),
    .frame_err(frame_err),
    .busy(busy)
`ifdef SSEG_RX_FRAME_CNT_EN
    ,
    .good_cnt(good_cnt),
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic shift_bit(input logic b);
    sdi    = b;
    sclk_i = 1'b0;
    repeat (4) @(negedge clk);
    sclk_i = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Sends n bits of data MSB first; with merge the last sclk rise and the
  // load rise are driven on the same clk edge.
  task automatic run_frame(input logic [127:0] data, input int n, input bit merge,
                           input string name);
    int k;
    bit got_v, got_e, exp_good;
    load_i = 1'b0;
    sclk_i = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      if (merge && i == 0) begin
        sdi    = data[0];
        sclk_i = 1'b0;
        repeat (4) @(negedge clk);
      end else begin
        shift_bit(data[i]);
      end
      if (i == n - 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_shift: got %b want 1", name, busy);
        end
      end
    end
    if (!merge) begin
      sclk_i = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      sclk_i = 1'b1;
    end
    load_i = 1'b1;

    exp_good = (n == FB);
    if (exp_good) begin
      seg_exp = data[FB-1:0];
      gcnt_exp = (gcnt_exp + 1) % 65536;
    end else if (ecnt_exp < 255) begin
      ecnt_exp++;
    end

    k = 0; got_v = 1'b0; got_e = 1'b0;
    for (int c = 1; c <= 12 && k == 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_vld || frame_err) begin
        k = c;
        got_v = frame_vld;
        got_e = frame_err;
      end
    end
    checks++;
    if (k != LAT + 1) begin
      errors++;
      $display("FAIL %s latency: got pulse at edge %0d want edge %0d (0 = none)", name, k, LAT + 1);
    end
    checks++;
    if ({got_v, got_e} !== {exp_good, !exp_good}) begin
      errors++;
      $display("FAIL %s kind: got vld=%b err=%b want vld=%b err=%b", name, got_v, got_e,
               exp_good, !exp_good);
    end
    checks++;
    if (seg_o !== seg_exp) begin
      errors++;
      $display("FAIL %s seg_o: got %h want %h", name, seg_o, seg_exp);
    end
`ifdef SSEG_RX_FRAME_CNT_EN
    checks++;
    if (good_cnt !== 16'(gcnt_exp) || err_cnt !== 8'(ecnt_exp)) begin
      errors++;
      $display("FAIL %s counters: got good=%0d err=%0d want good=%0d err=%0d", name,
               good_cnt, err_cnt, gcnt_exp, ecnt_exp);
    end
`endif
    @(negedge clk);
    checks++;
    if (frame_vld !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_width: got vld=%b err=%b want 0 0", name, frame_vld, frame_err);
    end
    sclk_i = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_idle: got %b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b0; load_i = 1'b1; sclk_i = 1'b0; sdi = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (seg_o !== '0 || busy !== 1'b0 || frame_vld !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got seg=%h busy=%b vld=%b err=%b want all 0", seg_o, busy,
               frame_vld, frame_err);
    end
    rst = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (frame_vld || frame_err || busy || seg_o != '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_idle: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_good_frame();
    run_frame(128'hF0FF_1234_FF56_780F, 64, 1'b0, "good_frame");
  endtask

  task automatic test_short_frame();
    run_frame(128'h1234_5678_9ABC_DEF0, 63, 1'b0, "short_frame");
  endtask

  task automatic test_overrun();
    run_frame(128'h2A_0123_4567_89AB_CDEF, 70, 1'b0, "overrun");
    run_frame(128'hA5A5_A5A5_A5A5_A5A5, 64, 1'b0, "after_overrun");
  endtask

  task automatic test_merge();
    run_frame(128'h8000_0000_0000_0001, 64, 1'b1, "merge_lsb1");
    run_frame(128'h7FFF_FFFF_FFFF_FFFE, 64, 1'b1, "merge_lsb0");
  endtask

  task automatic test_reset_mid();
    load_i = 1'b0;
    sclk_i = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 20; i++) shift_bit(1'($urandom_range(0, 1)));
    rst = 1'b0;
    load_i = 1'b1;
    sclk_i = 1'b0;
    #1;
    checks++;
    if (seg_o !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got seg=%h busy=%b want 0 0", seg_o, busy);
    end
    seg_exp = '0;
    gcnt_exp = 0;
    ecnt_exp = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    run_frame(128'h1, 64, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int lens[6] = '{64, 63, 0, 65, 64, 70};
    logic [127:0] d;
    bit m;
    for (int f = 0; f < 6; f++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      m = (lens[f] > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_frame(d, lens[f], m, $sformatf("rand%0d_len%0d", f, lens[f]));
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_overrun();
    test_merge();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
